// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_pkg
// Brief    : Shared encodings for the two-requester data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef XLEN
`define XLEN 32
`endif

package dmem_arb_pkg;
    localparam int c_XLEN = `XLEN;

    localparam logic [1:0] c_SIZE_B = 2'b00;
    localparam logic [1:0] c_SIZE_H = 2'b01;
    localparam logic [1:0] c_SIZE_W = 2'b10;
    localparam logic [1:0] c_SIZE_X = 2'b11;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ACC  = 2'd1;
    localparam logic [1:0] c_ST_RSP  = 2'd2;

    localparam logic [3:0] c_AMP_NONE = 4'b0000;
    localparam logic [3:0] c_AMP_B    = 4'b0001;
    localparam logic [3:0] c_AMP_HLO  = 4'b0011;
    localparam logic [3:0] c_AMP_HHI  = 4'b1100;
    localparam logic [3:0] c_AMP_W    = 4'b1111;
endpackage
`default_nettype wire

// File: rtl/dmem_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_if
// Brief    : Requester-side command/response bundle of the dmem arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_arb_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic            we;
    logic [1:0]      size;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;
    logic            err;

    modport master (output req, we, size, addr, wdata,
                    input  gnt, rvalid, rdata, err);
    modport slave  (input  req, we, size, addr, wdata,
                    output gnt, rvalid, rdata, err);
endinterface
`default_nettype wire

// File: rtl/dmem_lane.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lane
// Brief    : Byte-lane mask, alignment check and load-lane extraction.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lane
    import dmem_arb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic [1:0]      i_size,
    input  wire logic [1:0]      i_addr_lo,
    input  wire logic [XLEN-1:0] i_rd,
    output logic      [3:0]      o_amp,
    output logic                 o_err,
    output logic      [XLEN-1:0] o_rdata
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rd[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rd[31:16] : i_rd[15:0];

    always_comb begin
        o_amp   = c_AMP_NONE;
        o_err   = 1'b0;
        o_rdata = '0;
        case (i_size)
            c_SIZE_B: begin
                o_amp   = c_AMP_B << i_addr_lo;
                o_rdata = {{(XLEN-8){1'b0}}, w_byte};
            end
            c_SIZE_H: begin
                if (i_addr_lo[0]) begin
                    o_err = 1'b1;
                end else begin
                    o_amp   = i_addr_lo[1] ? c_AMP_HHI : c_AMP_HLO;
                    o_rdata = {{(XLEN-16){1'b0}}, w_half};
                end
            end
            c_SIZE_W: begin
                if (i_addr_lo != 2'b00) begin
                    o_err = 1'b1;
                end else begin
                    o_amp   = c_AMP_W;
                    o_rdata = i_rd;
                end
            end
            default: o_err = 1'b1;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/dmem_arb.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb
// Brief    : Round-robin two-requester arbiter for a single-port data memory.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arb
    import dmem_arb_pkg::*;
#(
    parameter int XLEN = c_XLEN
) (
    input  wire logic            clk,
    input  wire logic            rstn,
    dmem_arb_if.slave            m0,
    dmem_arb_if.slave            m1,
    output logic                 mem_we,
    output logic      [3:0]      mem_amp,
    output logic      [XLEN-1:0] mem_a,
    output logic      [XLEN-1:0] mem_wd,
    input  wire logic [XLEN-1:0] mem_rd
);
    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic            r_we;
    logic [1:0]      r_size;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic            r_id;
    logic            r_last;
    logic [XLEN-1:0] r_rdata;
    logic            r_err;

    logic            w_gnt0, w_gnt1, w_accept, w_open;
    logic [3:0]      w_amp;
    logic            w_err;
    logic [XLEN-1:0] w_lane_rdata;

    dmem_lane #(.XLEN(XLEN)) u_lane (
        .i_size    (r_size),
        .i_addr_lo (r_addr[1:0]),
        .i_rd      (mem_rd),
        .o_amp     (w_amp),
        .o_err     (w_err),
        .o_rdata   (w_lane_rdata)
    );

    // r_last names the requester granted most recently; a tie goes to the other.
    assign w_open   = rstn && (r_state == c_ST_IDLE || r_state == c_ST_RSP);
    assign w_gnt0   = w_open && m0.req && (!m1.req || r_last);
    assign w_gnt1   = w_open && m1.req && (!m0.req || !r_last);
    assign w_accept = w_gnt0 || w_gnt1;

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= c_ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = c_ST_IDLE;
        case (r_state)
            c_ST_IDLE: w_next = w_accept ? c_ST_ACC : c_ST_IDLE;
            c_ST_ACC:  w_next = c_ST_RSP;
            c_ST_RSP:  w_next = w_accept ? c_ST_ACC : c_ST_IDLE;
            default:   w_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_we    <= 1'b0;
            r_size  <= c_SIZE_B;
            r_addr  <= '0;
            r_wdata <= '0;
            r_id    <= 1'b0;
            r_last  <= 1'b1;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= w_gnt1 ? m1.we    : m0.we;
                r_size  <= w_gnt1 ? m1.size  : m0.size;
                r_addr  <= w_gnt1 ? m1.addr  : m0.addr;
                r_wdata <= w_gnt1 ? m1.wdata : m0.wdata;
                r_id    <= w_gnt1;
                r_last  <= w_gnt1;
            end
            if (r_state == c_ST_ACC) begin
                r_rdata <= (r_we || w_err) ? '0 : w_lane_rdata;
                r_err   <= w_err;
            end
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_amp   = c_AMP_NONE;
        mem_a     = '0;
        mem_wd    = '0;
        m0.gnt    = w_gnt0;
        m1.gnt    = w_gnt1;
        m0.rvalid = 1'b0;
        m0.rdata  = '0;
        m0.err    = 1'b0;
        m1.rvalid = 1'b0;
        m1.rdata  = '0;
        m1.err    = 1'b0;
        if (rstn && r_state == c_ST_ACC) begin
            mem_we  = r_we && !w_err;
            mem_amp = w_amp;
            mem_a   = r_addr;
            mem_wd  = r_wdata;
        end
        if (rstn && r_state == c_ST_RSP) begin
            if (r_id) begin
                m1.rvalid = 1'b1;
                m1.rdata  = r_rdata;
                m1.err    = r_err;
            end else begin
                m0.rvalid = 1'b1;
                m0.rdata  = r_rdata;
                m0.err    = r_err;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dmem_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arb
// Brief    : Directed bench for dmem_arb with a right-justified lane memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arb;
    logic        clk;
    logic        rstn;
    logic        clr;
    logic        mem_we;
    logic [3:0]  mem_amp;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic [31:0] mem [0:63];

    int n_checks;
    int n_fail;

    dmem_arb_if #(.XLEN(32)) b0 ();
    dmem_arb_if #(.XLEN(32)) b1 ();

    dmem_arb #(.XLEN(32)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .m0      (b0),
        .m1      (b1),
        .mem_we  (mem_we),
        .mem_amp (mem_amp),
        .mem_a   (mem_a),
        .mem_wd  (mem_wd),
        .mem_rd  (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory takes right-justified data for byte/half stores and places it by mask.
    function automatic logic [7:0] lane_src(input int i);
        if (mem_amp == 4'hF)                        return mem_wd[8*i +: 8];
        else if (mem_amp == 4'h3 || mem_amp == 4'hC) return mem_wd[8*(i%2) +: 8];
        else                                        return mem_wd[7:0];
    endfunction

    assign mem_rd = mem[mem_a[7:2]];

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else if (mem_we) begin
            for (int i = 0; i < 4; i++)
                if (mem_amp[i]) mem[mem_a[7:2]][8*i +: 8] <= lane_src(i);
        end
    end

    typedef struct {
        logic        m;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_we;
        logic [3:0]  exp_amp;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic m, input logic req, input logic we,
                         input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata);
        if (!m) begin
            b0.req = req; b0.we = we; b0.size = size; b0.addr = addr; b0.wdata = wdata;
        end else begin
            b1.req = req; b1.we = we; b1.size = size; b1.addr = addr; b1.wdata = wdata;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        drive(v.m, 1'b1, v.we, v.size, v.addr, v.wdata);
        #1;
        chk($sformatf("v%0d gnt", idx),       v.m ? b1.gnt : b0.gnt, 1);
        chk($sformatf("v%0d gnt_other", idx), v.m ? b0.gnt : b1.gnt, 0);
        @(posedge clk); #1;
        drive(v.m, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        chk($sformatf("v%0d mem_we", idx),  mem_we,  v.exp_we);
        chk($sformatf("v%0d mem_amp", idx), mem_amp, v.exp_amp);
        chk($sformatf("v%0d mem_a", idx),   mem_a,   v.addr);
        chk($sformatf("v%0d mem_wd", idx),  mem_wd,  v.wdata);
        @(posedge clk); #1;
        chk($sformatf("v%0d rvalid", idx),       v.m ? b1.rvalid : b0.rvalid, 1);
        chk($sformatf("v%0d rdata", idx),        v.m ? b1.rdata  : b0.rdata,  v.exp_rdata);
        chk($sformatf("v%0d err", idx),          v.m ? b1.err    : b0.err,    v.exp_err);
        chk($sformatf("v%0d rvalid_other", idx), v.m ? b0.rvalid : b1.rvalid, 0);
        chk($sformatf("v%0d rsp_mem_we", idx),   mem_we,  0);
        chk($sformatf("v%0d rsp_mem_amp", idx),  mem_amp, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        //          m     we    size   addr          wdata          we    amp    rdata          err
        vecs[0]  = '{1'b0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 1'b1, 4'hF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 1'b0, 2'b10, 32'h10, 32'h0,        1'b0, 4'hF, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 2'b00, 32'h13, 32'hAB,       1'b1, 4'h8, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 1'b0, 2'b00, 32'h13, 32'h0,        1'b0, 4'h8, 32'h000000AB, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 2'b01, 32'h12, 32'h0,        1'b0, 4'hC, 32'h0000ABAD, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 2'b01, 32'h10, 32'h0,        1'b0, 4'h3, 32'h0000BEEF, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 2'b00, 32'h11, 32'h0,        1'b0, 4'h2, 32'h000000BE, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 2'b01, 32'h22, 32'h12345678, 1'b1, 4'hC, 32'h0,        1'b0};
        vecs[8]  = '{1'b0, 1'b0, 2'b10, 32'h20, 32'h0,        1'b0, 4'hF, 32'h56780000, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 2'b01, 32'h21, 32'hFFFF,     1'b0, 4'h0, 32'h0,        1'b1};
        vecs[10] = '{1'b0, 1'b1, 2'b11, 32'h20, 32'hFFFFFFFF, 1'b0, 4'h0, 32'h0,        1'b1};
        vecs[11] = '{1'b1, 1'b0, 2'b10, 32'h22, 32'h0,        1'b0, 4'h0, 32'h0,        1'b1};
        vecs[12] = '{1'b1, 1'b0, 2'b10, 32'h20, 32'h0,        1'b0, 4'hF, 32'h56780000, 1'b0};

        rstn = 1'b0;
        clr  = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 2'b10, 32'h10, 32'h55);
        drive(1'b1, 1'b1, 1'b1, 2'b10, 32'h10, 32'h66);
        repeat (3) @(posedge clk);
        #1;
        chk("rst gnt0",    b0.gnt,    0);
        chk("rst gnt1",    b1.gnt,    0);
        chk("rst rvalid0", b0.rvalid, 0);
        chk("rst rvalid1", b1.rvalid, 0);
        chk("rst rdata0",  b0.rdata,  0);
        chk("rst err1",    b1.err,    0);
        chk("rst mem_we",  mem_we,    0);
        chk("rst mem_amp", mem_amp,   0);
        chk("rst mem_a",   mem_a,     0);
        chk("rst mem_wd",  mem_wd,    0);
        clr = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        rstn = 1'b1;

        for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

        // Reset during the ACC cycle of an m1 store must drop it entirely.
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 2'b10, 32'h40, 32'h1234);
        #1;
        chk("rA gnt1", b1.gnt, 1);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        chk("rA acc mem_we", mem_we, 1);
        rstn = 1'b0;
        #1;
        chk("rA rst mem_we",  mem_we,  0);
        chk("rA rst mem_amp", mem_amp, 0);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk($sformatf("rA c%0d rvalid1", c), b1.rvalid, 0);
            chk($sformatf("rA c%0d rvalid0", c), b0.rvalid, 0);
        end
        drive(1'b0, 1'b1, 1'b0, 2'b10, 32'h40, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 2'b10, 32'h40, 32'h0);
        #1;
        chk("rA held gnt0", b0.gnt, 0);
        chk("rA held gnt1", b1.gnt, 0);
        rstn = 1'b1;

        // Both hold req: grants alternate every second cycle starting with m0.
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin
                @(posedge clk); #2;
            end else begin
                #1;
            end
            chk($sformatf("rr k%0d gnt0", k), b0.gnt, (k % 4 == 0));
            chk($sformatf("rr k%0d gnt1", k), b1.gnt, (k % 4 == 2));
            if (k % 2 == 1) begin
                chk($sformatf("rr k%0d mem_a", k),  mem_a,  32'h40);
                chk($sformatf("rr k%0d mem_we", k), mem_we, 0);
            end
            if (k >= 2 && k % 2 == 0) begin
                chk($sformatf("rr k%0d rvalid0", k), b0.rvalid, (k % 4 == 2));
                chk($sformatf("rr k%0d rvalid1", k), b1.rvalid, (k % 4 == 0));
                chk($sformatf("rr k%0d rdata", k), (k % 4 == 2) ? b0.rdata : b1.rdata, 32'h0);
            end
        end

        // m0 was granted last; a reset must restore m0 as the tie winner.
        drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 1'b0, 2'b10, 32'h40, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 2'b10, 32'h40, 32'h0);
        rstn = 1'b1;
        #1;
        chk("rB tie gnt0", b0.gnt, 1);
        chk("rB tie gnt1", b1.gnt, 0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dmem_arb.md
DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 Parameter: XLEN, 32, data/address width (matches `XLEN).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rstn  in  1  synchronous active-low reset.
REQ-004 mN_req  in  1  requester N (N=0 CPU, N=1 loader/debug) has a valid command.
REQ-005 mN_we  in  1  command is a store (1) or load (0).
REQ-006 mN_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-007 mN_addr  in  XLEN  byte address.
REQ-008 mN_wdata  in  XLEN  store data, right-justified.
REQ-009 mN_gnt  out  1  command accepted this cycle (combinational).
REQ-010 mN_rvalid  out  1  one-cycle completion pulse.
REQ-011 mN_rdata  out  XLEN  load data, lane-extracted, zero-extended.
REQ-012 mN_err  out  1  qualifies mN_rvalid; misaligned/illegal command.
REQ-013 mem_we  out  1  dmem write enable.
REQ-014 mem_amp  out  4  dmem byte-lane mask.
REQ-015 mem_a  out  XLEN  dmem address.
REQ-016 mem_wd  out  XLEN  dmem write data.
REQ-017 mem_rd  in  XLEN  dmem combinational read data.

Function
REQ-018 FSM states IDLE, ACC, RSP; IDLE->ACC on accept; ACC->RSP always; RSP->ACC on accept, else IDLE.
REQ-019 Accept occurs in a cycle where state is IDLE or RSP and mN_req&&mN_gnt; at most one gnt high per cycle.
REQ-020 On accept, we/size/addr/wdata/requester-id are latched; requester may change inputs the next cycle.
REQ-021 Arbitration is round-robin: single request wins; with both requesting, winner is the requester not granted last; pointer updates only on accept.
REQ-022 Latency fixed: accept at T, memory access at T+1 (ACC), mN_rvalid at T+2 (RSP); peak throughput one access per 2 cycles.
REQ-023 In ACC: mem_a = latched addr, mem_wd = latched wdata unshifted, mem_amp per REQ-024, mem_we = latched we && !err && rstn.
REQ-024 amp: byte 0001<<addr[1:0]; half 0011 if addr[1]=0 else 1100; word 1111.
REQ-025 Error when size=11, half with addr[0]=1, or word with addr[1:0]!=0; no write, mem_amp=0, rdata=0, err=1 at RSP.
REQ-026 Load: mem_rd captured at end of ACC; byte/half lane selected by addr[1:0] and zero-extended; word passed through.
REQ-027 Store completion: rvalid=1, rdata=0, err=0.
REQ-028 rvalid/rdata/err driven only to the latched requester; other requester's outputs 0.
REQ-029 Outside ACC, mem_we, mem_amp, mem_a, mem_wd all 0.

Reset
REQ-030 While rstn=0: gnt, rvalid, err, rdata, mem_* outputs 0, state IDLE, round-robin pointer = m1 (m0 wins first tie).
REQ-031 rstn low during ACC suppresses the write at that edge; the in-flight command is dropped with no rvalid.
REQ-032 First accept possible in the first cycle after rstn rises.

Structure
REQ-033 Package dmem_arb_pkg holds size encodings, state encoding, and amp constants; XLEN comes from xgriscv_defines.
REQ-034 One combinational sub-module dmem_lane: amp generation, misalignment check, load lane extraction.

Verification
REQ-035 m0 sw addr 0x10 data 0xDEADBEEF, then lw 0x10 -> mem_amp 1111 at T+1; lw rvalid at T+2 with rdata 0xDEADBEEF, err 0.
REQ-036 m1 sb addr 0x13 data 0xAB -> mem_amp 1000; subsequent m1 lbu-style load 0x13 returns 0x000000AB.
REQ-037 m0 and m1 hold req continuously -> accepts alternate m0,m1,m0,m1, one every 2 cycles; neither starves.
REQ-038 m0 half store addr 0x21 -> no mem_we, mem_amp 0, rvalid with err=1 at T+2; size=11 gives the same result.
REQ-039 rstn low in ACC of m1 sw 0x40 data 0x1234 -> no write (read back 0x40 unchanged), no rvalid; after reset m0 wins a tie.
